// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a cmd/rsp handshake into AW/W/B or AR/R
// transactions, with a per-phase timeout so every accepted command yields a response.
module axi4_lite_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    output logic                      rready
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ,
        S_RDATA,
        S_DONE
    } state_t;

    state_t                    state, state_next;
    logic [CNT_W-1:0]          cnt;
    logic                      cmd_ready_q;
    logic                      aw_done, w_done;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   wstrb_q;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q;
    logic [1:0]                rsp_resp_q;
    logic                      rsp_timeout_q;
    logic                      accept;
    logic                      timeout_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Valids/readies decode from registered state only, so none depends on its ready.
    always_comb begin
        state_next  = state;
        accept      = cmd_valid && cmd_ready_q;
        timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        rsp_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_next = cmd_write ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) state_next = S_WRESP;
                else if (timeout_hit)                           state_next = S_DONE;
            end
            S_WRESP: begin
                bready = 1'b1;
                if (bvalid || timeout_hit) state_next = S_DONE;
            end
            S_READ: begin
                arvalid = 1'b1;
                if (arready)          state_next = S_RDATA;
                else if (timeout_hit) state_next = S_DONE;
            end
            S_RDATA: begin
                rready = 1'b1;
                if (rvalid || timeout_hit) state_next = S_DONE;
            end
            S_DONE: begin
                rsp_valid  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready_q   <= 1'b0;
            cnt           <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cmd_ready_q <= (state_next == S_IDLE);
            if (state_next != state || state_next == S_IDLE || state_next == S_DONE)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            // Timeout response is loaded first; a completing handshake overrides it.
            if (state_next == S_DONE && state != S_DONE) begin
                rsp_rdata_q   <= '0;
                rsp_resp_q    <= 2'b10;
                rsp_timeout_q <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (awready) aw_done <= 1'b1;
                    if (wready)  w_done  <= 1'b1;
                end
                S_WRESP: begin
                    if (bvalid) begin
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= bresp;
                        rsp_timeout_q <= 1'b0;
                    end
                end
                S_RDATA: begin
                    if (rvalid) begin
                        rsp_rdata_q   <= rdata;
                        rsp_resp_q    <= rresp;
                        rsp_timeout_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign awaddr      = addr_q;
    assign araddr      = addr_q;
    assign wdata       = wdata_q;
    assign wstrb       = wstrb_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master against a small behavioural 16-register slave.
module tb_axi4_lite_master;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [3:0]  awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [3:0]  araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_count = 0;
    int overlap_cnt = 0;
    int rsp_snap;

    logic [7:0]  aw_delay;
    logic        ar_en;

    axi4_lite_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: combinational ready, registered B/R response; addr 7 writes return SLVERR.
    logic [31:0] regs [16];
    logic [7:0]  aw_wait;
    logic        aw_got, w_got;
    logic [3:0]  aw_addr_l;
    logic [31:0] w_data_l;
    logic [3:0]  w_strb_l;
    logic        bvalid_r, rvalid_r;
    logic [1:0]  bresp_r;
    logic [31:0] rdata_r;
    logic        aw_hs, w_hs, ar_hs;
    logic [3:0]  a_addr;
    logic [31:0] a_data;
    logic [3:0]  a_strb;

    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = wvalid;
    assign arready = arvalid && ar_en;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign a_addr  = aw_hs ? awaddr : aw_addr_l;
    assign a_data  = w_hs ? wdata : w_data_l;
    assign a_strb  = w_hs ? wstrb : w_strb_l;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;
    assign rresp   = 2'b00;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aw_wait   <= '0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_l <= '0;
            w_data_l  <= '0;
            w_strb_l  <= '0;
            bvalid_r  <= 1'b0;
            bresp_r   <= '0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= 32'h1000_0000 + i;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 8'd1 : 8'd0;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
                bvalid_r <= 1'b1;
                if (a_addr == 4'd7) begin
                    bresp_r <= 2'b10;
                end else begin
                    bresp_r <= 2'b00;
                    for (int b = 0; b < 4; b++)
                        if (a_strb[b]) regs[a_addr][8*b +: 8] <= a_data[8*b +: 8];
                end
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= awaddr; end
                if (w_hs)  begin w_got <= 1'b1; w_data_l <= wdata; w_strb_l <= wstrb; end
            end
            if (bvalid_r && bready) bvalid_r <= 1'b0;
            if (ar_hs) begin
                rvalid_r <= 1'b1;
                rdata_r  <= regs[araddr];
            end else if (rvalid_r && rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_valid) rsp_count++;
        if (awvalid && arvalid) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [3:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = 4'hF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        aw_delay = 8'd0; ar_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_awvalid",   32'(awvalid),   32'd0);
        check("rst_wvalid",    32'(wvalid),    32'd0);
        check("rst_arvalid",   32'(arvalid),   32'd0);
        check("rst_bready",    32'(bready),    32'd0);
        check("rst_rready",    32'(rready),    32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        reset_n = 1'b1;
        step();
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // 1: write then read back addr 4
        drive(1'b1, 4'd4, 32'hDEAD_BEEF);
        step(); cmd_valid = 1'b0;
        check("t1_awvalid", 32'(awvalid), 32'd1);
        check("t1_wvalid",  32'(wvalid),  32'd1);
        check("t1_awaddr",  32'(awaddr),  32'd4);
        check("t1_wdata",   wdata,        32'hDEAD_BEEF);
        check("t1_wstrb",   32'(wstrb),   32'hF);
        check("t1_busy",    32'(cmd_ready), 32'd0);
        step();
        check("t1_awvalid_drop", 32'(awvalid), 32'd0);
        check("t1_bready",  32'(bready),  32'd1);
        step();
        check("t1_wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_wr_rsp_resp",  32'(rsp_resp),  32'd0);
        check("t1_wr_rsp_rdata", rsp_rdata,      32'd0);
        step();
        check("t1_rsp_pulse",  32'(rsp_valid), 32'd0);
        check("t1_ready_back", 32'(cmd_ready), 32'd1);
        drive(1'b0, 4'd4, 32'd0);
        step(); cmd_valid = 1'b0;
        check("t1_arvalid", 32'(arvalid), 32'd1);
        check("t1_araddr",  32'(araddr),  32'd4);
        step();
        check("t1_rready",  32'(rready),  32'd1);
        step();
        check("t1_rd_rsp_valid",   32'(rsp_valid),   32'd1);
        check("t1_rd_rsp_rdata",   rsp_rdata,        32'hDEAD_BEEF);
        check("t1_rd_rsp_resp",    32'(rsp_resp),    32'd0);
        check("t1_rd_rsp_timeout", 32'(rsp_timeout), 32'd0);
        step();
        check("t1_rd_ready_back", 32'(cmd_ready), 32'd1);

        // 2: awready delayed 3 cycles, wready immediate
        aw_delay = 8'd3;
        drive(1'b1, 4'd9, 32'hA5A5_0001);
        step(); cmd_valid = 1'b0;
        check("t2_wvalid_c1", 32'(wvalid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t2_awvalid_held", 32'(awvalid), 32'd1);
            check("t2_awaddr_stable", 32'(awaddr), 32'd9);
            check("t2_wdata_stable",  wdata,       32'hA5A5_0001);
            step();
            if (i == 0) check("t2_wvalid_drop", 32'(wvalid), 32'd0);
        end
        check("t2_awvalid_drop", 32'(awvalid), 32'd0);
        check("t2_bready",       32'(bready),  32'd1);
        step();
        check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t2_rsp_resp",  32'(rsp_resp),  32'd0);
        step();
        check("t2_single_rsp", 32'(rsp_count), 32'd3);
        check("t2_ready_back", 32'(cmd_ready), 32'd1);
        aw_delay = 8'd0;

        // 3: read timeout with arready tied low
        ar_en = 1'b0;
        drive(1'b0, 4'd3, 32'd0);
        step(); cmd_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("t3_arvalid_held", 32'(arvalid), 32'd1);
            step();
        end
        check("t3_arvalid_drop",  32'(arvalid),     32'd0);
        check("t3_rsp_valid",     32'(rsp_valid),   32'd1);
        check("t3_rsp_resp",      32'(rsp_resp),    32'd2);
        check("t3_rsp_timeout",   32'(rsp_timeout), 32'd1);
        check("t3_rsp_rdata",     rsp_rdata,        32'd0);
        step();
        check("t3_ready_back", 32'(cmd_ready), 32'd1);
        ar_en = 1'b1;

        // 4: reset asserted during WRESP
        rsp_snap = rsp_count;
        drive(1'b1, 4'd5, 32'h0000_0055);
        step(); cmd_valid = 1'b0;
        step();
        check("t4_bready_before", 32'(bready), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t4_bready_async",    32'(bready),    32'd0);
        check("t4_awvalid_async",   32'(awvalid),   32'd0);
        check("t4_wvalid_async",    32'(wvalid),    32'd0);
        check("t4_cmd_ready_async", 32'(cmd_ready), 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        check("t4_no_rsp",     32'(rsp_count), 32'(rsp_snap));
        check("t4_ready_back", 32'(cmd_ready), 32'd1);
        drive(1'b0, 4'd2, 32'd0);
        step(); cmd_valid = 1'b0;
        step();
        step();
        check("t4_rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t4_rd_rsp_rdata", rsp_rdata,      32'h1000_0002);
        check("t4_rd_rsp_resp",  32'(rsp_resp),  32'd0);
        step();

        // 5: back-to-back commands with cmd_valid held high
        drive(1'b1, 4'd0, 32'h0000_0001);
        step();
        drive(1'b1, 4'd15, 32'h0000_0002);
        check("t5a_awvalid", 32'(awvalid), 32'd1);
        check("t5a_busy_c1", 32'(cmd_ready), 32'd0);
        step();
        check("t5a_busy_c2", 32'(cmd_ready), 32'd0);
        step();
        check("t5a_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t5a_busy_c3",   32'(cmd_ready), 32'd0);
        step();
        check("t5a_ready_c4", 32'(cmd_ready), 32'd1);
        step();
        drive(1'b0, 4'd15, 32'd0);
        check("t5b_awaddr",  32'(awaddr),  32'd15);
        check("t5b_wdata",   wdata,        32'h0000_0002);
        check("t5b_busy_c1", 32'(cmd_ready), 32'd0);
        step();
        step();
        check("t5b_rsp_valid", 32'(rsp_valid), 32'd1);
        step();
        check("t5b_ready_c4", 32'(cmd_ready), 32'd1);
        step(); cmd_valid = 1'b0;
        check("t5c_arvalid", 32'(arvalid), 32'd1);
        check("t5c_awvalid", 32'(awvalid), 32'd0);
        check("t5c_araddr",  32'(araddr),  32'd15);
        step();
        step();
        check("t5c_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t5c_rsp_rdata", rsp_rdata,      32'h0000_0002);
        step();
        check("t5_no_overlap", 32'(overlap_cnt), 32'd0);

        // 6: slave error response on addr 7
        drive(1'b1, 4'd7, 32'h0000_0077);
        step(); cmd_valid = 1'b0;
        step();
        step();
        check("t6_rsp_valid",   32'(rsp_valid),   32'd1);
        check("t6_rsp_resp",    32'(rsp_resp),    32'd2);
        check("t6_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("t6_rsp_rdata",   rsp_rdata,        32'd0);
        step();
        check("total_rsp_count", 32'(rsp_count), 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
Single-outstanding AXI4-Lite master that sits directly upstream of the team's 16-register AXI4-Lite slave and drives all five of its channels. It converts a simple command/response interface (test sequencer or CPU-side logic) into AW/W/B or AR/R transactions. One transaction is in flight at a time. A per-phase timeout guarantees completion even if the slave never responds.

Parameters:
ADDR_WIDTH, 4, width of awaddr/araddr and cmd_addr (word index into slave register file)
DATA_WIDTH, 32, width of data buses; strobe width is DATA_WIDTH/8
TIMEOUT, 16, cycles allowed in any single wait phase before abort (must be >= 2)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  target address
cmd_wdata  input  DATA_WIDTH  write data
cmd_wstrb  input  DATA_WIDTH/8  write byte strobes
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_resp  output  2  AXI response (bresp/rresp, or 2'b10 on timeout)
rsp_timeout  output  1  qualifies rsp_valid: transaction aborted by timeout
awaddr  output  ADDR_WIDTH;  awvalid  output  1;  awready  input  1
wdata  output  DATA_WIDTH;  wstrb  output  DATA_WIDTH/8;  wvalid  output  1;  wready  input  1
bresp  input  2;  bvalid  input  1;  bready  output  1
araddr  output  ADDR_WIDTH;  arvalid  output  1;  arready  input  1
rdata  input  DATA_WIDTH;  rresp  input  2;  rvalid  input  1;  rready  output  1

Behaviour:
- Clock/reset: one clock `clk`; `reset_n` is asynchronous, active-low. While reset_n is low, all outputs are 0, including cmd_ready. The FSM is in IDLE.
- States: IDLE, WRITE (AW/W phase), WRESP, READ (AR phase), RDATA, DONE.
- IDLE: cmd_ready=1. On accept, register addr/wdata/wstrb/write. Go to WRITE (set awvalid=wvalid=1) or READ (set arvalid=1). Addr/data outputs are registered and stable while the corresponding valid is high.
- WRITE: awvalid drops the cycle after the AW handshake and wvalid drops the cycle after the W handshake. The two handshakes are tracked independently and may complete in the same or different cycles. Once both are done, go to WRESP with bready=1.
- WRESP: on bvalid, capture bresp, drop bready and go to DONE.
- READ: arvalid is held until arready. Then go to RDATA with rready=1.
- RDATA: on rvalid, capture rdata/rresp, drop rready and go to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then return to IDLE. There is no response backpressure. cmd_ready=0 in every state except IDLE.
- Valid rules: no valid output depends combinationally on its ready. Once asserted, a valid holds until its handshake completes, a timeout occurs, or reset.
- Latency with a slave that has combinational ready and a registered response, accept at edge T0:
  - valids high in cycle 1;
  - response in cycle 2;
  - rsp_valid in cycle 3;
  - next command accepted at edge T4.
- Timeout:
  - A counter clears on entering WRITE, WRESP, READ or RDATA and increments each cycle in that state.
  - When it reaches TIMEOUT-1 without the state's exit condition, all AXI valids/readies drop next cycle and the FSM goes to DONE.
  - Response: rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
  - If the exit condition and the timeout occur in the same cycle, the handshake wins (normal completion).
- Writes: rsp_rdata=0 and rsp_resp=bresp. Reads: rsp_resp=rresp.
- Reset mid-transaction: all valids/readies deassert immediately (asynchronous). Partially complete handshake state is discarded and no rsp_valid is issued.
- A cmd_valid that changes while cmd_ready=0 is ignored. Commands are never queued.

Test Plan:
1. Write addr 4, data 0xDEADBEEF, wstrb 0xF, then read addr 4 -> write rsp_valid in cycle 3 with rsp_resp=0. Read rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_timeout=0.
2. Write with awready delayed 3 cycles while wready is immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, awaddr/wdata stable throughout, single rsp_valid.
3. Read with arready tied 0 and TIMEOUT=16 -> arvalid held 16 cycles then drops. rsp_valid with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0. cmd_ready returns to 1 the next cycle.
4. Assert reset_n low in the WRESP cycle of a write -> bready, awvalid, wvalid and cmd_ready go 0 asynchronously. No rsp_valid. After release, a read of addr 2 completes normally.
5. Issue back-to-back commands with cmd_valid held high (write 0x1 to addr 0, write 0x2 to addr 15, read addr 15) -> one command is accepted every 4 cycles. Final rsp_rdata=0x00000002. No overlap of AW/AR valids.
6. Slave returns bresp=2'b10 on a write to addr 7 -> rsp_resp=2'b10, rsp_timeout=0.
